// File: rtl/game_draw_pkg.sv
// Shared draw-path definitions: screen geometry and the scanner state encoding.
package game_draw_pkg;

   localparam int unsigned DRAW_SCREEN_W = 160;
   localparam int unsigned DRAW_SCREEN_H = 120;

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StDrain,
      StDone
   } draw_state_e;

endpackage

// File: rtl/draw_delay_line.sv
// Enable-gated shift register with synchronous clear; DEPTH=0 is a plain wire.
module draw_delay_line
   import game_draw_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   if (DEPTH == 0) begin : g_pass
      assign dout = din;
   end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk) begin
         if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
         end else if (en) begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
         end
      end

      assign dout = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/rect_raster_scanner.sv
// Row-major rectangle sweeper for the VGA draw path: emits ROM address now and
// pixel x/y/plot delayed by MEM_LAT enabled cycles so they line up with ROM data.
module rect_raster_scanner
   import game_draw_pkg::*;
#(
   parameter int unsigned X_W      = 8,
   parameter int unsigned Y_W      = 7,
   parameter int unsigned ADDR_W   = 15,
   parameter int unsigned SCREEN_W = DRAW_SCREEN_W,
   parameter int unsigned SCREEN_H = DRAW_SCREEN_H,
   parameter int unsigned MEM_LAT  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              full,
   input  logic [X_W-1:0]    xOrigin,
   input  logic [Y_W-1:0]    yOrigin,
   input  logic [X_W-1:0]    width,
   input  logic [Y_W-1:0]    height,
   input  logic              ready,
   output logic [ADDR_W-1:0] addr,
   output logic [X_W-1:0]    x,
   output logic [Y_W-1:0]    y,
   output logic              plot,
   output logic              busy,
   output logic              done
);

   localparam int unsigned    DW      = X_W + Y_W + 1;
   localparam logic [X_W:0]   SCR_W_X = SCREEN_W[X_W:0];
   localparam logic [Y_W:0]   SCR_H_Y = SCREEN_H[Y_W:0];
   localparam logic [2:0]     LAT_M1  = (MEM_LAT == 0) ? 3'd0 : 3'(MEM_LAT - 1);

   draw_state_e state_q, state_d;

   logic [X_W-1:0]    org_x_q, org_x_d, w_q, w_d, col_q, col_d;
   logic [Y_W-1:0]    org_y_q, org_y_d, h_q, h_d, row_q, row_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        drain_q, drain_d;

   logic              issue, issue_valid, last_col, last_row;
   logic [X_W:0]      ix;
   logic [Y_W:0]      iy;
   logic [DW-1:0]     dly_in, dly_out;
   logic              plot_raw;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         org_x_q <= '0;
         org_y_q <= '0;
         w_q     <= '0;
         h_q     <= '0;
         col_q   <= '0;
         row_q   <= '0;
         addr_q  <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         org_x_q <= org_x_d;
         org_y_q <= org_y_d;
         w_q     <= w_d;
         h_q     <= h_d;
         col_q   <= col_d;
         row_q   <= row_d;
         addr_q  <= addr_d;
         drain_q <= drain_d;
      end
   end

   assign last_col = (col_q == w_q - X_W'(1));
   assign last_row = (row_q == h_q - Y_W'(1));

   always_comb begin
      state_d = state_q;
      org_x_d = org_x_q;
      org_y_d = org_y_q;
      w_d     = w_q;
      h_d     = h_q;
      col_d   = col_q;
      row_d   = row_q;
      addr_d  = addr_q;
      drain_d = drain_q;
      issue   = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               col_d   = '0;
               row_d   = '0;
               addr_d  = '0;
               drain_d = '0;
               if (full) begin
                  org_x_d = '0;
                  org_y_d = '0;
                  w_d     = SCR_W_X[X_W-1:0];
                  h_d     = SCR_H_Y[Y_W-1:0];
                  state_d = StScan;
               end else begin
                  org_x_d = xOrigin;
                  org_y_d = yOrigin;
                  w_d     = width;
                  h_d     = height;
                  state_d = (width == '0 || height == '0) ? StDone : StScan;
               end
            end
         end
         StScan: begin
            if (ready) begin
               issue  = 1'b1;
               addr_d = addr_q + ADDR_W'(1);
               if (last_col) begin
                  col_d = '0;
                  if (last_row) state_d = (MEM_LAT == 0) ? StDone : StDrain;
                  else          row_d   = row_q + Y_W'(1);
               end else begin
                  col_d = col_q + X_W'(1);
               end
            end
         end
         StDrain: begin
            // Counts enabled cycles only, so the final pixel still reaches the output.
            if (ready) begin
               if (drain_q == LAT_M1) state_d = StDone;
               else                   drain_d = drain_q + 3'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // One extra bit so off-screen coordinates compare correctly instead of wrapping.
   assign ix          = {1'b0, org_x_q} + {1'b0, col_q};
   assign iy          = {1'b0, org_y_q} + {1'b0, row_q};
   assign issue_valid = issue && (ix < SCR_W_X) && (iy < SCR_H_Y);
   assign dly_in      = {ix[X_W-1:0], iy[Y_W-1:0], issue_valid};

   draw_delay_line #(
      .WIDTH (DW),
      .DEPTH (MEM_LAT)
   ) u_delay (
      .clk   (clk),
      .reset (reset),
      .en    (ready),
      .din   (dly_in),
      .dout  (dly_out)
   );

   assign {x, y, plot_raw} = dly_out;
   assign plot = plot_raw && (state_q == StScan || state_q == StDrain);
   assign addr = addr_q;
   assign busy = (state_q != StIdle);
   assign done = (state_q == StDone);

endmodule
